// File: rtl/risc_pkg.sv
// risc_pkg: shared constants for the Simple RISC Machine controller.
// Holds opcode values, ALU operation codes (same encoding as the ALU),
// writeback select codes, the controller state enum and a sign-extend helper.
package risc_pkg;

  // Major opcodes (IR[15:13])
  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  // Minor op field values for the MOV opcode (IR[12:11])
  localparam logic [1:0] MOV_OP_REG = 2'b00;
  localparam logic [1:0] MOV_OP_IMM = 2'b10;

  // ALU operation codes; the ALU opcode's op field uses the same values
  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_AND  = 2'b10;
  localparam logic [1:0] ALU_INVB = 2'b11;

  // Writeback select
  localparam logic [1:0] VSEL_C   = 2'b00;
  localparam logic [1:0] VSEL_IMM = 2'b01;

  typedef enum logic [2:0] {
    S_WAIT      = 3'd0,
    S_DECODE    = 3'd1,
    S_GETA      = 3'd2,
    S_GETB      = 3'd3,
    S_COMPUTE   = 3'd4,
    S_WRITE_REG = 3'd5,
    S_WRITE_IMM = 3'd6
  } state_t;

  // Sign-extend an 8-bit immediate to 16 bits
  function automatic logic [15:0] sext8(input logic [7:0] v);
    return {{8{v[7]}}, v};
  endfunction

endpackage

// File: rtl/risc_instr_decode.sv
// risc_instr_decode: combinational field extractor and classifier.
// Ports:
//   i_ir         instruction register contents
//   o_opcode/o_op/o_rn/o_rd/o_sh/o_rm  raw fields
//   o_is_mov_imm MOV Rn,#imm8
//   o_is_mov_reg single-operand path (MOV Rd,Rm or MVN Rd,Rm): skips GetA
//   o_is_alu     two-operand path (ADD/CMP/AND): reads Rn then Rm
//   o_illegal    none of the above
//   o_sximm8     sign-extended IR[7:0]
module risc_instr_decode
  import risc_pkg::*;
(
  input  logic [15:0] i_ir,
  output logic [2:0]  o_opcode,
  output logic [1:0]  o_op,
  output logic [2:0]  o_rn,
  output logic [2:0]  o_rd,
  output logic [1:0]  o_sh,
  output logic [2:0]  o_rm,
  output logic        o_is_mov_imm,
  output logic        o_is_mov_reg,
  output logic        o_is_alu,
  output logic        o_illegal,
  output logic [15:0] o_sximm8
);

  logic w_opc_mov;
  logic w_opc_alu;

  assign o_opcode = i_ir[15:13];
  assign o_op     = i_ir[12:11];
  assign o_rn     = i_ir[10:8];
  assign o_rd     = i_ir[7:5];
  assign o_sh     = i_ir[4:3];
  assign o_rm     = i_ir[2:0];
  assign o_sximm8 = sext8(i_ir[7:0]);

  assign w_opc_mov = (o_opcode == OPC_MOV);
  assign w_opc_alu = (o_opcode == OPC_ALU);

  assign o_is_mov_imm = w_opc_mov && (o_op == MOV_OP_IMM);
  assign o_is_mov_reg = (w_opc_mov && (o_op == MOV_OP_REG)) ||
                        (w_opc_alu && (o_op == ALU_INVB));
  assign o_is_alu     = w_opc_alu && (o_op != ALU_INVB);
  assign o_illegal    = !(o_is_mov_imm || o_is_mov_reg || o_is_alu);

endmodule

// File: rtl/risc_controller.sv
// risc_controller: multi-cycle control FSM for the 16-bit Simple RISC datapath.
// Accepts one instruction per Start/Done handshake, sequences register-file
// reads/writes and the A/B/C/status load strobes, and drives AluOp/Shift.
// All outputs are Moore, decoded from the state and IR registers only.
// Ports:
//   clk, ResetN               clock, async active-low reset
//   Start, Instr              instruction launch (sampled only in Wait)
//   AluZero/AluOvf/AluSign    ALU flags, latched on CMP
//   ReadNum/WriteNum/Write    register-file control
//   LoadA/LoadB/LoadC/LoadS   datapath load strobes
//   AselZero/Vsel/Shift/AluOp datapath selects
//   Sximm8                    sign-extended IR[7:0]
//   Busy/Done/Err             handshake and illegal-instruction flag
//   StatusZ/StatusV/StatusN   registered status flags
module risc_controller
  import risc_pkg::*;
#(
  parameter int InstrWidth = 16,
  parameter int RegBits    = 3
) (
  input  logic                  clk,
  input  logic                  ResetN,
  input  logic                  Start,
  input  logic [InstrWidth-1:0] Instr,
  input  logic                  AluZero,
  input  logic                  AluOvf,
  input  logic                  AluSign,
  output logic [RegBits-1:0]    ReadNum,
  output logic [RegBits-1:0]    WriteNum,
  output logic                  Write,
  output logic                  LoadA,
  output logic                  LoadB,
  output logic                  LoadC,
  output logic                  LoadS,
  output logic                  AselZero,
  output logic [1:0]            Vsel,
  output logic [1:0]            Shift,
  output logic [1:0]            AluOp,
  output logic [InstrWidth-1:0] Sximm8,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Err,
  output logic                  StatusZ,
  output logic                  StatusV,
  output logic                  StatusN
);

  state_t                r_state;
  state_t                w_next_state;
  logic [InstrWidth-1:0] r_ir;

  logic [2:0]  w_opcode;
  logic [1:0]  w_op;
  logic [2:0]  w_rn;
  logic [2:0]  w_rd;
  logic [1:0]  w_sh;
  logic [2:0]  w_rm;
  logic        w_is_mov_imm;
  logic        w_is_mov_reg;
  logic        w_is_alu;
  logic        w_illegal;
  logic        w_is_cmp;

  risc_instr_decode u_decode (
    .i_ir         (r_ir),
    .o_opcode     (w_opcode),
    .o_op         (w_op),
    .o_rn         (w_rn),
    .o_rd         (w_rd),
    .o_sh         (w_sh),
    .o_rm         (w_rm),
    .o_is_mov_imm (w_is_mov_imm),
    .o_is_mov_reg (w_is_mov_reg),
    .o_is_alu     (w_is_alu),
    .o_illegal    (w_illegal),
    .o_sximm8     (Sximm8)
  );

  // CMP is the ALU opcode with the subtract op; it ends in Compute
  assign w_is_cmp = (w_opcode == OPC_ALU) && (w_op == ALU_SUB);
  assign Busy     = (r_state != S_WAIT);

  // State register and IR capture; IR is only loaded when Start is accepted
  always_ff @(posedge clk or negedge ResetN) begin
    if (!ResetN) begin
      r_state <= S_WAIT;
      r_ir    <= {InstrWidth{1'b0}};
    end else begin
      r_state <= w_next_state;
      if ((r_state == S_WAIT) && Start) begin
        r_ir <= Instr;
      end else begin
        r_ir <= r_ir;
      end
    end
  end

  // Status flags follow the ALU only on the CMP compute edge
  always_ff @(posedge clk or negedge ResetN) begin
    if (!ResetN) begin
      StatusZ <= 1'b0;
      StatusV <= 1'b0;
      StatusN <= 1'b0;
    end else if (LoadS) begin
      StatusZ <= AluZero;
      StatusV <= AluOvf;
      StatusN <= AluSign;
    end else begin
      StatusZ <= StatusZ;
      StatusV <= StatusV;
      StatusN <= StatusN;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_WAIT: begin
        if (Start) begin
          w_next_state = S_DECODE;
        end else begin
          w_next_state = S_WAIT;
        end
      end
      S_DECODE: begin
        if (w_is_mov_imm) begin
          w_next_state = S_WRITE_IMM;
        end else if (w_is_mov_reg) begin
          w_next_state = S_GETB;
        end else if (w_is_alu) begin
          w_next_state = S_GETA;
        end else begin
          w_next_state = S_WAIT;
        end
      end
      S_GETA:      w_next_state = S_GETB;
      S_GETB:      w_next_state = S_COMPUTE;
      S_COMPUTE: begin
        if (w_is_cmp) begin
          w_next_state = S_WAIT;
        end else begin
          w_next_state = S_WRITE_REG;
        end
      end
      S_WRITE_REG: w_next_state = S_WAIT;
      S_WRITE_IMM: w_next_state = S_WAIT;
      default:     w_next_state = S_WAIT;
    endcase
  end

  // Moore output decode from state and IR
  always_comb begin
    ReadNum  = {RegBits{1'b0}};
    WriteNum = {RegBits{1'b0}};
    Write    = 1'b0;
    LoadA    = 1'b0;
    LoadB    = 1'b0;
    LoadC    = 1'b0;
    LoadS    = 1'b0;
    AselZero = 1'b0;
    Vsel     = VSEL_C;
    Shift    = 2'b00;
    AluOp    = ALU_ADD;
    Done     = 1'b0;
    Err      = 1'b0;
    case (r_state)
      S_WAIT: begin
        Done = 1'b0;
      end
      S_DECODE: begin
        if (w_illegal) begin
          Done = 1'b1;
          Err  = 1'b1;
        end else begin
          Done = 1'b0;
        end
      end
      S_GETA: begin
        ReadNum = w_rn;
        LoadA   = 1'b1;
      end
      S_GETB: begin
        ReadNum = w_rm;
        LoadB   = 1'b1;
      end
      S_COMPUTE: begin
        Shift = w_sh;
        if (w_opcode == OPC_ALU) begin
          // ALU op field already matches the ALU's own encoding
          AluOp = w_op;
          if (w_is_cmp) begin
            LoadS = 1'b1;
            Done  = 1'b1;
          end else begin
            LoadC = 1'b1;
          end
        end else begin
          // MOV Rd,Rm is computed as 0 + shifted Rm
          AluOp    = ALU_ADD;
          AselZero = 1'b1;
          LoadC    = 1'b1;
        end
      end
      S_WRITE_REG: begin
        Write    = 1'b1;
        WriteNum = w_rd;
        Vsel     = VSEL_C;
        Done     = 1'b1;
      end
      S_WRITE_IMM: begin
        Write    = 1'b1;
        WriteNum = w_rn;
        Vsel     = VSEL_IMM;
        Done     = 1'b1;
      end
      default: begin
        Done = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_risc_controller.sv
// tb_risc_controller: directed self-checking bench for risc_controller.
module tb_risc_controller;

  logic        clk;
  logic        ResetN;
  logic        Start;
  logic [15:0] Instr;
  logic        AluZero;
  logic        AluOvf;
  logic        AluSign;
  logic [2:0]  ReadNum;
  logic [2:0]  WriteNum;
  logic        Write;
  logic        LoadA;
  logic        LoadB;
  logic        LoadC;
  logic        LoadS;
  logic        AselZero;
  logic [1:0]  Vsel;
  logic [1:0]  Shift;
  logic [1:0]  AluOp;
  logic [15:0] Sximm8;
  logic        Busy;
  logic        Done;
  logic        Err;
  logic        StatusZ;
  logic        StatusV;
  logic        StatusN;

  int n_checks;
  int n_pass;
  logic write_seen;

  risc_controller #(.InstrWidth(16), .RegBits(3)) dut (
    .clk      (clk),
    .ResetN   (ResetN),
    .Start    (Start),
    .Instr    (Instr),
    .AluZero  (AluZero),
    .AluOvf   (AluOvf),
    .AluSign  (AluSign),
    .ReadNum  (ReadNum),
    .WriteNum (WriteNum),
    .Write    (Write),
    .LoadA    (LoadA),
    .LoadB    (LoadB),
    .LoadC    (LoadC),
    .LoadS    (LoadS),
    .AselZero (AselZero),
    .Vsel     (Vsel),
    .Shift    (Shift),
    .AluOp    (AluOp),
    .Sximm8   (Sximm8),
    .Busy     (Busy),
    .Done     (Done),
    .Err      (Err),
    .StatusZ  (StatusZ),
    .StatusV  (StatusV),
    .StatusN  (StatusN)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed === expected) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present an instruction for exactly one accept edge; returns in cycle 1 (Decode)
  task automatic launch(input logic [15:0] ins);
    Start = 1'b1;
    Instr = ins;
    step();
    Start = 1'b0;
    Instr = 16'h0000;
  endtask

  task automatic run_mov_imm(input string pfx);
    launch(16'hD3FB);
    check({pfx, "c1_busy"}, {31'd0, Busy}, 32'd1);
    check({pfx, "c1_write"}, {31'd0, Write}, 32'd0);
    check({pfx, "c1_done"}, {31'd0, Done}, 32'd0);
    step();
    check({pfx, "c2_write"}, {31'd0, Write}, 32'd1);
    check({pfx, "c2_writenum"}, {29'd0, WriteNum}, 32'd3);
    check({pfx, "c2_vsel"}, {30'd0, Vsel}, 32'd1);
    check({pfx, "c2_sximm8"}, {16'd0, Sximm8}, 32'h0000FFFB);
    check({pfx, "c2_done"}, {31'd0, Done}, 32'd1);
    check({pfx, "c2_err"}, {31'd0, Err}, 32'd0);
    step();
    check({pfx, "c3_busy"}, {31'd0, Busy}, 32'd0);
    check({pfx, "c3_done"}, {31'd0, Done}, 32'd0);
  endtask

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    write_seen = 1'b0;
    ResetN     = 1'b0;
    Start      = 1'b0;
    Instr      = 16'h0000;
    AluZero    = 1'b0;
    AluOvf     = 1'b0;
    AluSign    = 1'b0;
    #12;
    // Reset state
    check("rst_busy", {31'd0, Busy}, 32'd0);
    check("rst_done", {31'd0, Done}, 32'd0);
    check("rst_strobes", {26'd0, Write, LoadA, LoadB, LoadC, LoadS, AselZero}, 32'd0);
    check("rst_status", {29'd0, StatusZ, StatusV, StatusN}, 32'd0);
    check("rst_sximm8", {16'd0, Sximm8}, 32'd0);
    ResetN = 1'b1;
    step();

    // Test 1: MOV R3,#-5
    run_mov_imm("t1_");

    // Test 2: ADD R2,R1,R0 LSL#1
    launch(16'hA148);
    check("t2_c1_loada", {31'd0, LoadA}, 32'd0);
    step();
    check("t2_c2_readnum", {29'd0, ReadNum}, 32'd1);
    check("t2_c2_loada", {31'd0, LoadA}, 32'd1);
    check("t2_c2_loadb", {31'd0, LoadB}, 32'd0);
    step();
    check("t2_c3_readnum", {29'd0, ReadNum}, 32'd0);
    check("t2_c3_loadb", {31'd0, LoadB}, 32'd1);
    check("t2_c3_loada", {31'd0, LoadA}, 32'd0);
    step();
    check("t2_c4_aluop", {30'd0, AluOp}, 32'd0);
    check("t2_c4_shift", {30'd0, Shift}, 32'd1);
    check("t2_c4_loadc", {31'd0, LoadC}, 32'd1);
    check("t2_c4_aselzero", {31'd0, AselZero}, 32'd0);
    check("t2_c4_done", {31'd0, Done}, 32'd0);
    step();
    check("t2_c5_write", {31'd0, Write}, 32'd1);
    check("t2_c5_writenum", {29'd0, WriteNum}, 32'd2);
    check("t2_c5_vsel", {30'd0, Vsel}, 32'd0);
    check("t2_c5_done", {31'd0, Done}, 32'd1);
    check("t2_c5_shift", {30'd0, Shift}, 32'd0);
    step();
    check("t2_c6_busy", {31'd0, Busy}, 32'd0);

    // Test 3: CMP R1,R0 with Z=1 V=1 N=0
    AluZero = 1'b1;
    AluOvf  = 1'b1;
    AluSign = 1'b0;
    write_seen = 1'b0;
    launch(16'hA900);
    for (int c = 1; c <= 3; c++) begin
      write_seen = write_seen | Write;
      step();
    end
    write_seen = write_seen | Write;
    check("t3_c4_loads", {31'd0, LoadS}, 32'd1);
    check("t3_c4_loadc", {31'd0, LoadC}, 32'd0);
    check("t3_c4_aluop", {30'd0, AluOp}, 32'd1);
    check("t3_c4_done", {31'd0, Done}, 32'd1);
    check("t3_c4_status_pre", {29'd0, StatusZ, StatusV, StatusN}, 32'd0);
    check("t3_no_write", {31'd0, write_seen}, 32'd0);
    step();
    check("t3_status", {29'd0, StatusZ, StatusV, StatusN}, 32'b110);
    check("t3_c5_busy", {31'd0, Busy}, 32'd0);

    // Test 4: illegal instruction, flags must hold even with different ALU inputs
    AluZero = 1'b0;
    AluOvf  = 1'b0;
    AluSign = 1'b1;
    launch(16'h0000);
    check("t4_done", {31'd0, Done}, 32'd1);
    check("t4_err", {31'd0, Err}, 32'd1);
    check("t4_strobes", {26'd0, Write, LoadA, LoadB, LoadC, LoadS, AselZero}, 32'd0);
    step();
    check("t4_busy_after", {31'd0, Busy}, 32'd0);
    check("t4_err_after", {31'd0, Err}, 32'd0);
    check("t4_status", {29'd0, StatusZ, StatusV, StatusN}, 32'b110);

    // Test 5: reset during GetB of an ADD
    launch(16'hA148);
    step();
    step();
    check("t5_in_getb", {31'd0, LoadB}, 32'd1);
    #2;
    ResetN = 1'b0;
    #1;
    check("t5_rst_loadb", {31'd0, LoadB}, 32'd0);
    check("t5_rst_busy", {31'd0, Busy}, 32'd0);
    check("t5_rst_readnum", {29'd0, ReadNum}, 32'd0);
    check("t5_rst_status", {29'd0, StatusZ, StatusV, StatusN}, 32'd0);
    step();
    check("t5_rst_nowrite", {30'd0, Write, Done}, 32'd0);
    #2;
    ResetN = 1'b1;
    step();
    run_mov_imm("t5_");

    // Test 6: Start during Compute of an ADD is ignored
    launch(16'hA148);
    step();
    step();
    step();
    check("t6_c4_loadc", {31'd0, LoadC}, 32'd1);
    Start = 1'b1;
    Instr = 16'hBF00;
    step();
    Start = 1'b0;
    Instr = 16'h0000;
    check("t6_c5_write", {31'd0, Write}, 32'd1);
    check("t6_c5_writenum", {29'd0, WriteNum}, 32'd2);
    check("t6_c5_sximm8", {16'd0, Sximm8}, 32'h00000048);
    check("t6_c5_done", {31'd0, Done}, 32'd1);
    step();
    check("t6_c6_busy", {31'd0, Busy}, 32'd0);

    // Back-to-back: MVN R1,R2 accepted the cycle after Done, latency 4
    // 0xB822 = 101 11 000 001 00 010
    launch(16'hB822);
    step();
    check("b2b_c2_getb", {28'd0, LoadB, ReadNum}, 32'b1010);
    step();
    check("b2b_c3_aluop", {30'd0, AluOp}, 32'd3);
    check("b2b_c3_loadc", {31'd0, LoadC}, 32'd1);
    step();
    check("b2b_c4_write", {28'd0, Done, WriteNum}, 32'b1001);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/risc_controller.md
Name: risc_controller

Overview:
- Multi-cycle control FSM for the 16-bit Simple RISC Machine datapath.
- Accepts one instruction per Start/Done handshake and decodes it.
- Sequences register-file reads and writes and the A/B/C/status load strobes.
- Drives AluOp and Shift to the ALU. Latches the ALU's zero, overflow and sign results into a status register on CMP.

Parameters:
- InstrWidth, 16, instruction and immediate-output width; only 16 is supported.
- RegBits, 3, register index width (8 registers).

Ports:
- clk  in  1  rising-edge clock.
- ResetN  in  1  asynchronous, active-low reset.
- Start  in  1  launches an instruction; sampled only in Wait.
- Instr  in  16  instruction; captured into IR when Start is accepted.
- AluZero  in  1  ALU zero result (StatusOut).
- AluOvf  in  1  ALU OverflowOut.
- AluSign  in  1  ALU result bit 15.
- ReadNum  out  3  register file read index.
- WriteNum  out  3  register file write index.
- Write  out  1  register file write enable.
- LoadA  out  1  load strobe for the A register.
- LoadB  out  1  load strobe for the B register.
- LoadC  out  1  load strobe for the C register.
- LoadS  out  1  status register load (internal flops, also exported).
- AselZero  out  1  forces the ALU A input to zero.
- Vsel  out  2  writeback select: 00 = C, 01 = Sximm8.
- Shift  out  2  B-path shift code.
- AluOp  out  2  00 add, 01 subtract, 10 and, 11 invert-B.
- Sximm8  out  16  sign-extended IR[7:0].
- Busy  out  1  FSM is not in Wait.
- Done  out  1  one-cycle completion pulse.
- Err  out  1  illegal instruction; valid only while Done is high.
- StatusZ  out  1  registered zero flag.
- StatusV  out  1  registered overflow flag.
- StatusN  out  1  registered negative flag.

Behaviour:
- Async reset:
  - State goes to Wait, IR = 0, StatusZ/V/N = 0, all strobes 0, Done = 0, Busy = 0.
  - A reset mid-instruction aborts it immediately: no Write, no Done.
- Instruction fields: opcode = IR[15:13], op = IR[12:11], Rn = IR[10:8], Rd = IR[7:5], sh = IR[4:3], Rm = IR[2:0].
- Outputs are Moore: decoded from state and IR only. Any strobe not listed for a state is 0.
- Wait: if Start is high, IR <= Instr and go to Decode. Start is ignored in every other state.
- Decode:
  - opcode 110, op 10 (MOV imm) -> WriteImm.
  - opcode 110, op 00 (MOV reg) or opcode 101, op 11 (MVN) -> GetB.
  - opcode 101, op 00/01/10 (ADD/CMP/AND) -> GetA.
  - Anything else: assert Done = 1 and Err = 1, then go to Wait.
- GetA: ReadNum = Rn, LoadA = 1 -> GetB.
- GetB: ReadNum = Rm, LoadB = 1 -> Compute.
- Compute: Shift = sh.
  - ADD: AluOp = 00, LoadC = 1.
  - AND: AluOp = 10, LoadC = 1.
  - MVN: AluOp = 11, LoadC = 1.
  - MOV reg: AluOp = 00, AselZero = 1, LoadC = 1.
  - CMP: AluOp = 01, LoadS = 1, Done = 1, next state Wait.
  - All others then go to WriteReg.
- WriteReg: Write = 1, WriteNum = Rd, Vsel = 00, Done = 1 -> Wait.
- WriteImm: Write = 1, WriteNum = Rn, Vsel = 01, Done = 1 -> Wait.
- Status register: on a clock edge with LoadS = 1, StatusZ <= AluZero, StatusV <= AluOvf, StatusN <= AluSign. Otherwise the flags hold. Only CMP updates them.
- Latency, counted from the Start-accept edge to the Done cycle:
  - MOV imm: 2.
  - MOV reg / MVN: 4.
  - CMP: 4.
  - ADD / AND: 5.
  - Illegal: 1.
- Back-to-back: the earliest next Start accept is the cycle after Done.
- Shift is 0 outside Compute. Sximm8 is always the sign extension of IR[7:0].

Decomposition:
- Package risc_pkg holds:
  - opcode constants (MOV = 3'b110, ALU = 3'b101);
  - ALU op codes, identical to the ALU encoding: ADD 00, SUB 01, AND 10, INVB 11;
  - the Vsel encodings;
  - the state enum: Wait, Decode, GetA, GetB, Compute, WriteReg, WriteImm.
- One sub-module, risc_instr_decode: a combinational field extractor and classifier (isMovImm, isMovReg, isAlu, illegal, Sximm8).

Test Plan:
1. Start with Instr = 0xD3FB (MOV R3,#-5) -> Decode, then WriteImm. Second cycle after accept shows Write = 1, WriteNum = 3, Vsel = 01, Sximm8 = 0xFFFB, Done = 1.
2. Instr = 0xA148 (ADD R2,R1,R0 LSL#1) -> ReadNum 1 with LoadA; ReadNum 0 with LoadB; AluOp 00, Shift 01, LoadC; Write with WriteNum 2. Done at cycle 5.
3. Instr = 0xA900 (CMP R1,R0) with AluZero = 1, AluOvf = 1, AluSign = 0 in Compute -> LoadS at cycle 4. After that edge StatusZ = 1, V = 1, N = 0. Write never asserted; Done at cycle 4.
4. Instr = 0x0000 -> Done = 1 and Err = 1 at cycle 1. No strobes asserted; status unchanged.
5. ResetN low during GetB of test 2 -> outputs clear asynchronously and state is Wait. After release, test 1 passes unchanged.
6. Start pulsed with 0xBF00 during Compute of an ADD -> ignored. IR unchanged and the ADD writes R2.
